// File: rtl/ibex_pext_ex_seq_pkg.sv
// Shared types and constants for the P-extension execute-stage sequencer.
package ibex_pext_ex_seq_pkg;

  // Width of each ALU intermediate-value register (32-bit data plus carry/guard bits).
  localparam int unsigned PEXT_IMD_W = 34;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_BUSY = 2'd1,
    SEQ_HOLD = 2'd2
  } pext_seq_state_e;

endpackage

// File: rtl/ibex_pext_ex_seq_if.sv
// Sequencer <-> P-ALU connection: enable, completion, result and intermediate values.
interface ibex_pext_ex_seq_if;

  logic                                                alu_en;
  logic                                                valid;
  logic [31:0]                                         result;
  logic                                                set_ov;
  logic [1:0][ibex_pext_ex_seq_pkg::PEXT_IMD_W-1:0]    imd_val_d;
  logic [1:0]                                          imd_val_we;
  logic [1:0][ibex_pext_ex_seq_pkg::PEXT_IMD_W-1:0]    imd_val_q;

  // Sequencer side
  modport master (
    output alu_en, imd_val_q,
    input  valid, result, set_ov, imd_val_d, imd_val_we
  );

  // ALU side
  modport slave (
    input  alu_en, imd_val_q,
    output valid, result, set_ov, imd_val_d, imd_val_we
  );

endinterface

// File: rtl/ibex_pext_ex_seq_chk.sv
// Protocol checks on the sequencer's issue interface.
module ibex_pext_ex_seq_chk
  import ibex_pext_ex_seq_pkg::*;
(
  input logic            clk_i,
  input logic            rst_ni,
  input pext_seq_state_e state,
  input logic            en
);

  // ID must keep the instruction valid for the whole of a multi-cycle op
  a_en_held_in_busy: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state == SEQ_BUSY) |-> en);

endmodule

// File: rtl/ibex_pext_imd_regs.sv
// Two-entry intermediate-value register bank with per-entry write enable
// and a synchronous clear that overrides any write.
module ibex_pext_imd_regs
  import ibex_pext_ex_seq_pkg::*;
(
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        clr_i,
  input  logic [1:0]                  we_i,
  input  logic [1:0][PEXT_IMD_W-1:0]  d_i,
  output logic [1:0][PEXT_IMD_W-1:0]  q_o
);

  // Register bank: clear wins over per-entry writes
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_o <= '0;
    end else if (clr_i) begin
      q_o <= '0;
    end else begin
      for (int r = 0; r < 2; r++) begin
        if (we_i[r]) begin
          q_o[r] <= d_i[r];
        end
      end
    end
  end

endmodule

// File: rtl/ibex_pext_ex_seq.sv
// Execute-stage sequencer for the P-extension ALU: gates the ALU enable,
// owns the intermediate-value registers, tracks multi-cycle ops, holds a
// result while writeback stalls and maintains the sticky vxsat flag.
module ibex_pext_ex_seq
  import ibex_pext_ex_seq_pkg::*;
#(
  parameter int unsigned MaxCycles = 8,
  parameter bit          ResetAll  = 1'b0
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                en_i,
  input  logic                kill_i,
  input  logic                wb_ready_i,
  ibex_pext_ex_seq_if.master  alu,
  output logic [31:0]         result_o,
  output logic                wb_valid_o,
  output logic                ex_ready_o,
  output logic                vxsat_o,
  input  logic                vxsat_we_i,
  input  logic                vxsat_wdata_i,
  output logic                err_timeout_o
);

  localparam logic [7:0] MAX_CNT = 8'(MaxCycles);

  pext_seq_state_e state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [31:0]     hold_result_q;
  logic            hold_ov_q;
  logic            vxsat_q, vxsat_d;
  logic            live;
  logic            capture;
  logic            timeout;
  logic            ov;
  logic            retire_ov;

  // A live cycle is an un-killed valid instruction while the ALU may work on it
  assign live = en_i & ~kill_i & (state_q != SEQ_HOLD);

  ibex_pext_imd_regs u_imd_regs (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (timeout),
    .we_i   (alu.imd_val_we & {2{live}}),
    .d_i    (alu.imd_val_d),
    .q_o    (alu.imd_val_q)
  );

  // State and cycle-count registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= SEQ_IDLE;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic, including watchdog expiry and hold capture
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    timeout = 1'b0;
    case (state_q)
      SEQ_IDLE, SEQ_BUSY: begin
        if (kill_i || !en_i) begin
          state_d = SEQ_IDLE;
          cnt_d   = 8'd0;
        end else if (alu.valid) begin
          cnt_d = 8'd0;
          if (wb_ready_i) begin
            state_d = SEQ_IDLE;
          end else begin
            state_d = SEQ_HOLD;
            capture = 1'b1;
          end
        end else if (state_q == SEQ_IDLE) begin
          state_d = SEQ_BUSY;
          cnt_d   = 8'd1;
        end else if (cnt_q >= MAX_CNT) begin
          state_d = SEQ_IDLE;
          cnt_d   = 8'd0;
          timeout = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      SEQ_HOLD: begin
        if (wb_ready_i) begin
          state_d = SEQ_IDLE;
        end else begin
          state_d = SEQ_HOLD;
        end
      end
      default: begin
        state_d = SEQ_IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // Output logic: a live result or the held result is presented to writeback
  always_comb begin
    alu.alu_en    = live;
    wb_valid_o    = 1'b0;
    result_o      = 32'd0;
    ex_ready_o    = 1'b0;
    ov            = 1'b0;
    err_timeout_o = timeout;
    case (state_q)
      SEQ_IDLE, SEQ_BUSY: begin
        if (live && alu.valid) begin
          wb_valid_o = 1'b1;
          result_o   = alu.result;
          ov         = alu.set_ov;
          ex_ready_o = wb_ready_i;
        end else begin
          wb_valid_o = 1'b0;
        end
      end
      SEQ_HOLD: begin
        wb_valid_o = 1'b1;
        result_o   = hold_result_q;
        ov         = hold_ov_q;
        ex_ready_o = wb_ready_i;
      end
      default: begin
        wb_valid_o = 1'b0;
      end
    endcase
  end

  // Hold register: optionally left out of reset since it is only read in HOLD
  if (ResetAll) begin : g_hold_rst
    // Capture result and overflow when writeback stalls (with reset)
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        hold_result_q <= 32'd0;
        hold_ov_q     <= 1'b0;
      end else if (capture) begin
        hold_result_q <= alu.result;
        hold_ov_q     <= alu.set_ov;
      end
    end
  end else begin : g_hold_nrst
    // Capture result and overflow when writeback stalls (no reset)
    always_ff @(posedge clk_i) begin
      if (capture) begin
        hold_result_q <= alu.result;
        hold_ov_q     <= alu.set_ov;
      end
    end
  end

  assign retire_ov = wb_valid_o & wb_ready_i & ov;

  // Sticky saturation: a hardware set on retire always wins over a CSR clear
  always_comb begin
    vxsat_d = vxsat_q;
    if (vxsat_we_i) begin
      vxsat_d = vxsat_wdata_i | retire_ov;
    end else if (retire_ov) begin
      vxsat_d = 1'b1;
    end else begin
      vxsat_d = vxsat_q;
    end
  end

  // vxsat register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vxsat_q <= 1'b0;
    end else begin
      vxsat_q <= vxsat_d;
    end
  end

  assign vxsat_o = vxsat_q;

  ibex_pext_ex_seq_chk u_chk (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .state  (state_q),
    .en     (en_i)
  );

endmodule

// File: tb/tb_ibex_pext_ex_seq.sv
// Directed self-checking bench for ibex_pext_ex_seq.
module tb_ibex_pext_ex_seq;
  import ibex_pext_ex_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, kill, wb_ready, vxsat_we, vxsat_wdata;
  logic [31:0] result;
  logic        wb_valid, ex_ready, vxsat, err_timeout;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  ibex_pext_ex_seq_if alu_if ();

  ibex_pext_ex_seq #(.MaxCycles(8), .ResetAll(1'b0)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .en_i          (en),
    .kill_i        (kill),
    .wb_ready_i    (wb_ready),
    .alu           (alu_if),
    .result_o      (result),
    .wb_valid_o    (wb_valid),
    .ex_ready_o    (ex_ready),
    .vxsat_o       (vxsat),
    .vxsat_we_i    (vxsat_we),
    .vxsat_wdata_i (vxsat_wdata),
    .err_timeout_o (err_timeout)
  );

  task automatic drive_idle();
    en = 1'b0; kill = 1'b0; wb_ready = 1'b1; vxsat_we = 1'b0; vxsat_wdata = 1'b0;
    alu_if.valid = 1'b0; alu_if.result = 32'd0; alu_if.set_ov = 1'b0;
    alu_if.imd_val_d = '0; alu_if.imd_val_we = 2'b00;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_idle();
    #12;
    checks++; if (alu_if.imd_val_q !== 68'd0) begin errors++; $display("FAIL reset_imd got %h exp 0", alu_if.imd_val_q); end
    checks++; if (vxsat !== 1'b0) begin errors++; $display("FAIL reset_vxsat got %b exp 0", vxsat); end
    checks++; if ({wb_valid, ex_ready, err_timeout, alu_if.alu_en} !== 4'b0000) begin errors++; $display("FAIL reset_outs got %b exp 0000", {wb_valid, ex_ready, err_timeout, alu_if.alu_en}); end
    checks++; if (result !== 32'd0) begin errors++; $display("FAIL reset_result got %h exp 0", result); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++; if (dut.state_q !== SEQ_IDLE) begin errors++; $display("FAIL reset_state got %0d exp IDLE", dut.state_q); end
  endtask

  task automatic test_single();
    en = 1'b1; alu_if.valid = 1'b1; alu_if.result = 32'h1545_0015; wb_ready = 1'b1;
    #1;
    checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL single_wb_valid got %b exp 1", wb_valid); end
    checks++; if (result !== 32'h1545_0015) begin errors++; $display("FAIL single_result got %h exp 15450015", result); end
    checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL single_ex_ready got %b exp 1", ex_ready); end
    checks++; if (alu_if.alu_en !== 1'b1) begin errors++; $display("FAIL single_alu_en got %b exp 1", alu_if.alu_en); end
    step();
    drive_idle();
    checks++; if (dut.state_q !== SEQ_IDLE) begin errors++; $display("FAIL single_state got %0d exp IDLE", dut.state_q); end
  endtask

  task automatic test_multi();
    // cycle 1: write entry 0
    en = 1'b1; alu_if.imd_val_we = 2'b01; alu_if.imd_val_d[0] = 34'h0_0000_0050;
    #1;
    checks++; if (ex_ready !== 1'b0) begin errors++; $display("FAIL multi_c1_ex_ready got %b exp 0", ex_ready); end
    step();
    checks++; if (alu_if.imd_val_q[0] !== 34'h0_0000_0050) begin errors++; $display("FAIL multi_imd0 got %h exp 50", alu_if.imd_val_q[0]); end
    checks++; if (dut.state_q !== SEQ_BUSY) begin errors++; $display("FAIL multi_state_busy got %0d exp BUSY", dut.state_q); end
    // cycle 2: write entry 1
    alu_if.imd_val_we = 2'b10; alu_if.imd_val_d[1] = 34'h3_FFFF_FFFF;
    #1;
    checks++; if (ex_ready !== 1'b0) begin errors++; $display("FAIL multi_c2_ex_ready got %b exp 0", ex_ready); end
    step();
    checks++; if (alu_if.imd_val_q[1] !== 34'h3_FFFF_FFFF) begin errors++; $display("FAIL multi_imd1 got %h exp 3ffffffff", alu_if.imd_val_q[1]); end
    // cycle 3: result
    alu_if.imd_val_we = 2'b00; alu_if.valid = 1'b1; alu_if.result = 32'hA5A5_0001;
    #1;
    checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL multi_c3_ex_ready got %b exp 1", ex_ready); end
    checks++; if (result !== 32'hA5A5_0001) begin errors++; $display("FAIL multi_result got %h exp a5a50001", result); end
    step();
    drive_idle();
    checks++; if (dut.state_q !== SEQ_IDLE) begin errors++; $display("FAIL multi_state_idle got %0d exp IDLE", dut.state_q); end
  endtask

  task automatic test_hold();
    en = 1'b1; alu_if.valid = 1'b1; alu_if.result = 32'h8000_7FFF; alu_if.set_ov = 1'b1; wb_ready = 1'b0;
    #1;
    checks++; if ({wb_valid, ex_ready} !== 2'b10) begin errors++; $display("FAIL hold_c0 got %b exp 10", {wb_valid, ex_ready}); end
    step();
    // stalled cycle: ALU output changes, imd writes and kill must be ignored
    alu_if.valid = 1'b0; alu_if.result = 32'h0000_DEAD; alu_if.set_ov = 1'b0;
    alu_if.imd_val_we = 2'b11; alu_if.imd_val_d[0] = 34'h1_1111_1111; alu_if.imd_val_d[1] = 34'h2_2222_2222;
    kill = 1'b1;
    #1;
    checks++; if (alu_if.alu_en !== 1'b0) begin errors++; $display("FAIL hold_alu_en got %b exp 0", alu_if.alu_en); end
    checks++; if (result !== 32'h8000_7FFF) begin errors++; $display("FAIL hold_result got %h exp 80007fff", result); end
    checks++; if ({wb_valid, ex_ready} !== 2'b10) begin errors++; $display("FAIL hold_c1 got %b exp 10", {wb_valid, ex_ready}); end
    step();
    kill = 1'b0; alu_if.imd_val_we = 2'b00; wb_ready = 1'b1;
    #1;
    checks++; if ({wb_valid, ex_ready} !== 2'b11) begin errors++; $display("FAIL hold_accept got %b exp 11", {wb_valid, ex_ready}); end
    checks++; if (result !== 32'h8000_7FFF) begin errors++; $display("FAIL hold_accept_result got %h exp 80007fff", result); end
    step();
    drive_idle();
    checks++; if (vxsat !== 1'b1) begin errors++; $display("FAIL hold_vxsat got %b exp 1", vxsat); end
    checks++; if (dut.state_q !== SEQ_IDLE) begin errors++; $display("FAIL hold_state got %0d exp IDLE", dut.state_q); end
    checks++; if (alu_if.imd_val_q !== {34'h3_FFFF_FFFF, 34'h0_0000_0050}) begin errors++; $display("FAIL hold_imd got %h exp unchanged", alu_if.imd_val_q); end
  endtask

  task automatic test_csr_clear();
    vxsat_we = 1'b1; vxsat_wdata = 1'b0;
    step();
    drive_idle();
    checks++; if (vxsat !== 1'b0) begin errors++; $display("FAIL csr_clear got %b exp 0", vxsat); end
  endtask

  task automatic test_kill();
    en = 1'b1;
    step();
    kill = 1'b1; alu_if.imd_val_we = 2'b11;
    alu_if.imd_val_d[0] = 34'h0_0000_1234; alu_if.imd_val_d[1] = 34'h0_0000_5678;
    alu_if.valid = 1'b1; alu_if.result = 32'hFFFF_FFFF; alu_if.set_ov = 1'b1;
    #1;
    checks++; if ({wb_valid, ex_ready, alu_if.alu_en} !== 3'b000) begin errors++; $display("FAIL kill_outs got %b exp 000", {wb_valid, ex_ready, alu_if.alu_en}); end
    step();
    drive_idle();
    checks++; if (dut.state_q !== SEQ_IDLE) begin errors++; $display("FAIL kill_state got %0d exp IDLE", dut.state_q); end
    checks++; if (alu_if.imd_val_q !== {34'h3_FFFF_FFFF, 34'h0_0000_0050}) begin errors++; $display("FAIL kill_imd got %h exp unchanged", alu_if.imd_val_q); end
    checks++; if (vxsat !== 1'b0) begin errors++; $display("FAIL kill_vxsat got %b exp 0", vxsat); end
  endtask

  task automatic test_timeout();
    en = 1'b1; alu_if.imd_val_we = 2'b01; alu_if.imd_val_d[0] = 34'h0_0000_0077;
    #1;
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL timeout_issue got %b exp 0", err_timeout); end
    step();
    alu_if.imd_val_we = 2'b00;
    checks++; if (alu_if.imd_val_q[0] !== 34'h0_0000_0077) begin errors++; $display("FAIL timeout_imd0 got %h exp 77", alu_if.imd_val_q[0]); end
    for (int i = 1; i <= 8; i++) begin
      logic exp_err;
      exp_err = (i == 8);
      #1;
      checks++; if (err_timeout !== exp_err) begin errors++; $display("FAIL timeout_busy%0d got %b exp %b", i, err_timeout, exp_err); end
      step();
    end
    drive_idle();
    checks++; if (alu_if.imd_val_q !== 68'd0) begin errors++; $display("FAIL timeout_imd_clr got %h exp 0", alu_if.imd_val_q); end
    checks++; if (dut.state_q !== SEQ_IDLE) begin errors++; $display("FAIL timeout_state got %0d exp IDLE", dut.state_q); end
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL timeout_pulse got %b exp 0", err_timeout); end
  endtask

  task automatic test_vxsat_race();
    vxsat_we = 1'b1; vxsat_wdata = 1'b1;
    step();
    vxsat_we = 1'b0;
    checks++; if (vxsat !== 1'b1) begin errors++; $display("FAIL race_csr_set got %b exp 1", vxsat); end
    en = 1'b1; alu_if.valid = 1'b1; alu_if.result = 32'h0000_0001; alu_if.set_ov = 1'b1; wb_ready = 1'b1;
    vxsat_we = 1'b1; vxsat_wdata = 1'b0;
    #1;
    checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL race_ov_retire got %b exp 1", ex_ready); end
    step();
    checks++; if (vxsat !== 1'b1) begin errors++; $display("FAIL race_hw_wins got %b exp 1", vxsat); end
    alu_if.set_ov = 1'b0;
    step();
    drive_idle();
    checks++; if (vxsat !== 1'b0) begin errors++; $display("FAIL race_no_ov got %b exp 0", vxsat); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [3];
    vals[0] = 32'h0000_0011; vals[1] = 32'h2222_0000; vals[2] = 32'hCAFE_F00D;
    en = 1'b1; alu_if.valid = 1'b1; wb_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      alu_if.result = vals[i];
      #1;
      checks++; if ({wb_valid, ex_ready} !== 2'b11) begin errors++; $display("FAIL b2b_ready%0d got %b exp 11", i, {wb_valid, ex_ready}); end
      checks++; if (result !== vals[i]) begin errors++; $display("FAIL b2b_result%0d got %h exp %h", i, result, vals[i]); end
      step();
    end
    drive_idle();
    checks++; if (dut.state_q !== SEQ_IDLE) begin errors++; $display("FAIL b2b_state got %0d exp IDLE", dut.state_q); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_hold();
    test_csr_clear();
    test_kill();
    test_timeout();
    test_vxsat_race();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ibex_pext_ex_seq.md
Name: ibex_pext_ex_seq

Overview:
Execute-stage sequencer between the ID/EX issue logic and ibex_alu_pext. It owns the two 34-bit intermediate-value registers, gates the ALU multicycle enable and tracks multi-cycle Zpn ops to completion. It holds the result when writeback stalls and maintains the sticky P-extension saturation flag (vxsat). It replaces the ad-hoc imd register emulation around the P-ALU in the core.

Parameters:
MaxCycles, 8, watchdog limit on cycles an op may stay in BUSY before error (2..255)
ResetAll, 0, when 1 the hold result register is also reset

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
en_i  in  1  P-ALU instruction valid in EX
kill_i  in  1  flush current op (branch/exception)
wb_ready_i  in  1  writeback accepts result this cycle
alu_en_o  out  1  drives ALU mult_en_i/mult_sel_i
alu_valid_i  in  1  ALU valid_o
alu_result_i  in  32  ALU result_o
alu_set_ov_i  in  1  ALU set_ov_o
alu_imd_val_d_i  in  2x34  ALU imd_val_d_o
alu_imd_val_we_i  in  2  ALU imd_val_we_o
imd_val_q_o  out  2x34  to ALU imd_val_q_i
result_o  out  32  writeback data
wb_valid_o  out  1  result valid to writeback
ex_ready_o  out  1  op retired, ID may advance
vxsat_o  out  1  sticky saturation flag
vxsat_we_i  in  1  CSR write to vxsat
vxsat_wdata_i  in  1  CSR write data
err_timeout_o  out  1  one-cycle pulse, watchdog expired

Behaviour:
- Reset: state IDLE; imd_val_q_o = 0; vxsat_o = 0; cycle count 0; all outputs 0. The hold register resets only when ResetAll = 1.
- Live cycle: en_i & ~kill_i & state in {IDLE, BUSY}. alu_en_o = live cycle.
- imd regs: imd_val_q[r] <= alu_imd_val_d_i[r] when alu_imd_val_we_i[r] and live cycle. Updates are ignored otherwise, including under kill_i and in HOLD.
- IDLE, live cycle, alu_valid_i same cycle (single-cycle op):
  - wb_valid_o = 1 and result_o = alu_result_i (combinational).
  - If wb_ready_i: ex_ready_o = 1, stay IDLE.
  - Else: capture result and ov into the hold register, go to HOLD.
- IDLE, live cycle, no alu_valid_i: go to BUSY, cycle count <= 1.
- BUSY:
  - Each live cycle without valid increments the count.
  - alu_valid_i: retire exactly as in IDLE (to IDLE or HOLD).
  - Count reaches MaxCycles without valid: err_timeout_o pulses, go to IDLE, imd regs cleared to 0.
  - en_i low while BUSY: go to IDLE, no retire. ID must not deassert mid-op; this is an assertion.
- HOLD:
  - alu_en_o = 0; wb_valid_o = 1; result_o = held value.
  - wb_ready_i: ex_ready_o = 1, go to IDLE.
  - kill_i does not drop a held result, because it is already committed.
- kill_i in IDLE/BUSY: go to IDLE next cycle, count 0, no wb_valid_o, no vxsat update, imd regs untouched.
- vxsat:
  - Retire event = wb_valid_o & wb_ready_i with ov = 1 (live ov or held ov). A retire event sets vxsat.
  - CSR write same cycle as a retire event: vxsat <= vxsat_wdata_i | ov, so the hardware set wins.
  - CSR write alone: vxsat <= vxsat_wdata_i.
- Retire rate: at most one ex_ready_o per op; back-to-back single-cycle ops retire every cycle.

Decomposition:
- ibex_pkg_pext gains pext_seq_state_e {SEQ_IDLE, SEQ_BUSY, SEQ_HOLD} and the constant PEXT_IMD_W = 34.
- One sub-module: ibex_pext_imd_regs, the 2x34 register bank with per-entry write enable and synchronous clear. The FSM, counter, hold register and vxsat logic stay in the top.

Test Plan:
- Single-cycle op, alu_valid_i=1 same cycle, result 32'h1545_0015, wb_ready_i=1 -> wb_valid_o=1, result_o=32'h1545_0015, ex_ready_o=1 that cycle, state stays IDLE.
- ZPN_KMAXDA-style 3-cycle op: imd we=2'b01 then 2'b10 with d=34'h0_0000_0050 / 34'h3_FFFF_FFFF, valid on cycle 3 -> imd_val_q_o reflects each write the next cycle, ex_ready_o only on cycle 3.
- Valid with wb_ready_i=0 for 2 cycles, alu_set_ov_i=1 -> HOLD, result_o stable, alu_en_o=0; on wb_ready_i=1 ex_ready_o=1 and vxsat_o=1 the next cycle.
- kill_i in BUSY cycle 2 with imd we=2'b11 -> imd regs unchanged, no wb_valid_o, IDLE next cycle, vxsat_o unchanged.
- MaxCycles=8, alu_valid_i never asserted -> err_timeout_o pulses on the 8th BUSY cycle, imd regs = 0, state IDLE.
- vxsat_o=1, vxsat_we_i=1 with wdata 0 in the same cycle as an ov retire -> vxsat_o stays 1. Repeat without ov -> vxsat_o = 0.
